// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: FIFO-buffered west-edge feeder that skews lane i by i beats and flushes the array.
// Optional SKEW_FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module systolic_skew_feeder #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_last,
  output logic [N*W-1:0] edge_out,
  output logic           ce_out,
  output logic           pass_done
`ifdef SKEW_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * N) + 1;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
  state_t state_q, state_d;
  logic [N*W:0] mem_q [DEPTH];
  logic [N*W:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [CW-1:0] fl_q, fl_d;
  logic ce_q, ce_d, done_q, done_d;
  logic push, pop, adv, empty, pop_last;
  logic [N*W-1:0] lane_in;
  assign empty = cnt_q == '0;
  assign in_ready = !rst && cnt_q != (PW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state_q == STREAM && !empty;
  assign adv = pop || state_q == FLUSH;
  assign pop_last = pop && mem_q[rd_q][N*W];
  assign lane_in = pop ? mem_q[rd_q][N*W-1:0] : '0;
  assign ce_out = ce_q;
  assign pass_done = done_q;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {in_last, in_data};
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_comb begin
    state_d = state_q;
    fl_d = fl_q;
    case (state_q)
      IDLE: if (!empty) state_d = STREAM;
      STREAM: if (pop_last) begin
        state_d = N > 1 ? FLUSH : IDLE;
        fl_d = CW'(2 * N - 2);
      end
      FLUSH: begin
        fl_d = fl_q - CW'(1);
        if (fl_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ce_d = adv;
    done_d = (state_q == FLUSH && fl_q == CW'(1)) || (N == 1 && pop_last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      fl_q <= '0;
      ce_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      fl_q <= fl_d;
      ce_q <= ce_d;
      done_q <= done_d;
    end
    mem_q <= mem_d;
  end
  // Lane i is an (i+1)-deep delay line that only moves on adv, so stalls freeze the whole wavefront.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] dl_q [i+1];
    logic [W-1:0] dl_d [i+1];
    always_comb begin
      dl_d = dl_q;
      if (adv) begin
        dl_d[0] = lane_in[i*W +: W];
        for (int k = 1; k <= i; k++) dl_d[k] = dl_q[k-1];
      end
    end
    always_ff @(posedge clk) begin
      if (rst) dl_q <= '{default: '0};
      else dl_q <= dl_d;
    end
    assign edge_out[i*W +: W] = dl_q[i];
  end
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = (state_q == IDLE && state_d == STREAM) ? '0 :
                  (state_q == STREAM && !adv && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

West-edge feeder for the MAC systolic array. Accepts row vectors of N signed 16-bit lanes over a valid/ready handshake and buffers them in a small FIFO. It then drives them onto the array's west inputs with lane i delayed i beats, and generates the array clock-enable. After the last vector of a pass it injects zero beats until the array has drained, then pulses `pass_done`.

## Interface
- `N`, 4: lanes (array rows); N ≥ 1
- `W`, 16: lane width, two's complement
- `DEPTH`, 4: FIFO entries, power of two ≥ 2
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: input vector valid
- `in_ready` out 1: FIFO can accept a vector
- `in_data` in N*W: lane i at bits [i*W +: W]
- `in_last` in 1: final vector of a pass
- `edge_out` out N*W: skewed lanes to the array west inputs; lane i is at [i*W +: W]
- `ce_out` out 1: array clock-enable; high exactly when `edge_out` carries a new beat
- `pass_done` out 1: one-cycle pulse on the final drain beat

## Operation
- Reset values: `in_ready`=0 while `rst` is high and 1 after; `edge_out`=0; `ce_out`=0; `pass_done`=0; FIFO empty; FSM in IDLE; flush counter=0.
- FIFO stores {`in_last`, `in_data`}.
  - Push when `in_valid && in_ready`.
  - `in_ready` = !full, computed from the registered count.
  - No bypass path: a vector pushed into an empty FIFO is poppable the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
- Advance event `adv`: a pop in STREAM, or a zero beat in FLUSH.
  - On `adv`, lane 0 loads its new value. Lane i (i>0) shifts its i-deep delay line, so its output is the value from i advances earlier.
  - Without `adv`, all skew registers hold.
- `ce_out` <= `adv`. The array therefore sees a beat, and freezes with the feeder during stalls.
- FSM:
  - IDLE: if the FIFO is non-empty, move to STREAM. No `adv` in the transition cycle.
  - STREAM: each cycle the FIFO is non-empty, pop and `adv`. An empty FIFO is a stall: no `adv`, and the state is kept. If the popped entry has last=1 and N>1, load the flush counter with 2N−2 and go to FLUSH. If N=1, go directly to IDLE and assert `pass_done` with that beat.
  - FLUSH: inject an all-zero vector into lane 0 with `adv` every cycle, and decrement the counter. On the beat where the counter reaches 0, assert `pass_done` with that beat's `ce_out` and return to IDLE. Pushes remain accepted during FLUSH; pops wait until STREAM.
- Data is passed through unmodified. No arithmetic is applied to lane values.
- Reset mid-pass: the FIFO contents, skew registers and the pass are discarded. No `pass_done` is produced.

## Timing
- Latency: a vector popped in cycle c appears on lane 0 in c+1 with `ce_out`=1. Lane i shows it on the i-th subsequent `adv` beat (cycle c+1+i if there are no stalls).
- Minimum from push to first `ce_out`: a push in cycle t gives IDLE→STREAM in t+1, pop in t+2, and `ce_out` in t+3.
- Throughput is one vector per cycle while the FIFO is non-empty.
- Back-to-back passes: the next pass's first pop occurs no earlier than 1 cycle after the `pass_done` cycle (the IDLE transition).
- `pass_done` coincides with the last of 2N−2 zero beats. For a K-vector pass without stalls, it falls K+2N−2 beats after the first beat.

## Configuration
- `SKEW_FEEDER_STALL_CNT_EN`: defined → adds output `stall_cnt` [15:0].
  - The counter resets to 0, and to 0 at each STREAM entry from IDLE.
  - It increments on every STREAM cycle with no `adv`, and saturates at 16'hFFFF.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid`=1 → all outputs 0, `in_ready`=0. Release → `in_ready`=1 next cycle, with no push having been accepted during reset.
- Single pass, N=4:
  - Stimulus: push 4 vectors back-to-back, lane values 16'h0101·k (k=1..4), last on the 4th.
  - `ce_out` is high for 10 consecutive cycles.
  - Lane 3 first shows 16'h0101 on the 4th beat.
  - Zeros follow on every lane after its data.
  - `pass_done` is high only on the 10th beat.
- Stall: push vector 1, wait 5 cycles, then push vector 2 with last → `ce_out` drops during the gap. `edge_out` holds its value during the gap. Lane 1 shows vector 1 lane 1 on the first beat after the gap.
- Backpressure: `DEPTH`=4, hold `in_valid` while the FIFO is not draining (FLUSH of the previous pass) → `in_ready`=0 after 4 pushes. There is no loss or duplication; the 5th vector is accepted once a pop frees a slot.
- Signed passthrough: lane value 16'h8000 and 16'hFFFF → output bit-exact.
- Mid-pass reset: assert `rst` during FLUSH → `ce_out`=0 next cycle. No `pass_done` is produced, and the FIFO is empty afterward.
- `SKEW_FEEDER_STALL_CNT_EN` build: 5-cycle stall in STREAM → `stall_cnt`=5. The counter clears on the next pass start.
